// File: rtl/bcd_sevenseg_scan.sv
// bcd_sevenseg_scan
//   Drives a 4-digit, common-anode, multiplexed 7-segment display from four
//   BCD digits. One digit is lit for REFRESH_DIV cycles, then the scan moves
//   to the next digit. The BCD inputs are copied into a shadow register only
//   at the end of a full frame, so a value change never shows half-updated.
//   Optional leading-zero blanking; digits 10..15 show a dash.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   BCD_0..3    units / tens / hundreds / thousands digit
//   blank_lz    1 = blank leading zeros (sampled every cycle)
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   an          digit anodes, active-low, an[i] lights digit i, registered
//   frame_done  one-cycle pulse at the start of each new frame
module bcd_sevenseg_scan #(
  parameter  int REFRESH_DIV = 50000,
  localparam int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] BCD_0,
  input  logic [3:0] BCD_1,
  input  logic [3:0] BCD_2,
  input  logic [3:0] BCD_3,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       s0_q, s1_q, s2_q, s3_q;
  logic [3:0]       s0_d, s1_d, s2_d, s3_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  logic             div_wrap;
  logic             frame_end;
  logic [3:0]       cur_digit;
  logic             cur_blank;

  // Active-low glyphs; anything above 9 becomes a dash (segment g only).
  function automatic logic [6:0] seg7_decode(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h3F;
    endcase
    return g;
  endfunction

  always_comb begin
    div_wrap  = (div_cnt_q == DIV_MAX);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + CNT_W'(1);
    idx_d     = div_wrap ? idx_q + 2'd1 : idx_q;

    // Last cycle of the digit-3 slot closes the frame: capture new inputs.
    frame_end    = div_wrap && (idx_q == 2'd3);
    frame_done_d = frame_end;
    s0_d = frame_end ? BCD_0 : s0_q;
    s1_d = frame_end ? BCD_1 : s1_q;
    s2_d = frame_end ? BCD_2 : s2_q;
    s3_d = frame_end ? BCD_3 : s3_q;

    // A digit is a leading zero only if it and every higher digit are 0.
    // Invalid digits (>9) are nonzero, so they stop blanking below them.
    cur_digit = s0_q;
    cur_blank = 1'b0;
    case (idx_q)
      2'd0: begin
        cur_digit = s0_q;
        cur_blank = 1'b0;
      end
      2'd1: begin
        cur_digit = s1_q;
        cur_blank = blank_lz && (s3_q == 4'd0) && (s2_q == 4'd0) && (s1_q == 4'd0);
      end
      2'd2: begin
        cur_digit = s2_q;
        cur_blank = blank_lz && (s3_q == 4'd0) && (s2_q == 4'd0);
      end
      default: begin
        cur_digit = s3_q;
        cur_blank = blank_lz && (s3_q == 4'd0);
      end
    endcase

    seg_d = cur_blank ? 7'h7F : seg7_decode(cur_digit);
    an_d  = cur_blank ? 4'hF  : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= 2'd0;
      s0_q         <= 4'd0;
      s1_q         <= 4'd0;
      s2_q         <= 4'd0;
      s3_q         <= 4'd0;
      seg_q        <= 7'h7F;
      an_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Testbench for bcd_sevenseg_scan with REFRESH_DIV = 4.
// A behavioural model derives the expected display from the number of clock
// edges since reset: digit slot = ((n-1)/R) mod 4, frame boundary every 4R
// edges, shadow refreshed from the inputs at each boundary.
module tb_bcd_sevenseg_scan;

  localparam int R     = 4;
  localparam int FRAME = 4 * R;

  localparam logic [6:0] GLYPH [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] BCD_0 = 4'd0, BCD_1 = 4'd0, BCD_2 = 4'd0, BCD_3 = 4'd0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  int compared   = 0;
  int mismatched = 0;

  bcd_sevenseg_scan #(.REFRESH_DIV(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .BCD_0      (BCD_0),
    .BCD_1      (BCD_1),
    .BCD_2      (BCD_2),
    .BCD_3      (BCD_3),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural model
  int         mc   = 0;      // edges since the last reset edge
  bit         m_ok = 1'b0;
  int         sh [4];
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_fd;

  always @(posedge clk) begin
    if (rst) begin
      mc = 0;
      for (int j = 0; j < 4; j++) sh[j] = 0;
      e_seg = 7'h7F;
      e_an  = 4'hF;
      e_fd  = 1'b0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      int  d;
      bit  blanked;
      mc = mc + 1;
      d  = ((mc - 1) % FRAME) / R;
      blanked = blank_lz && (d > 0);
      for (int j = d; j < 4; j++) if (sh[j] != 0) blanked = 1'b0;
      if (blanked) begin
        e_seg = 7'h7F;
        e_an  = 4'hF;
      end else begin
        e_seg = GLYPH[sh[d]];
        e_an  = 4'hF & ~(4'(1) << d);
      end
      e_fd = ((mc % FRAME) == 0);
      if (e_fd) begin
        sh[0] = int'(BCD_0);
        sh[1] = int'(BCD_1);
        sh[2] = int'(BCD_2);
        sh[3] = int'(BCD_3);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ok) begin
      compared++;
      if (seg !== e_seg) begin
        mismatched++;
        $display("FAIL model_seg n=%0d got=%h exp=%h", mc, seg, e_seg);
      end
      compared++;
      if (an !== e_an) begin
        mismatched++;
        $display("FAIL model_an n=%0d got=%h exp=%h", mc, an, e_an);
      end
      compared++;
      if (frame_done !== e_fd) begin
        mismatched++;
        $display("FAIL model_fd n=%0d got=%b exp=%b", mc, frame_done, e_fd);
      end
    end
  end

  task automatic wait_n(input int target);
    for (int i = 0; i < 400 && mc != target; i++) @(negedge clk);
    if (mc != target) begin
      compared++;
      mismatched++;
      $display("FAIL wait_n reached=%0d exp=%0d", mc, target);
    end
  endtask

  task automatic lit(input string name, input int at, input logic [6:0] s,
                     input logic [3:0] a);
    wait_n(at);
    compared++;
    if (seg !== s || an !== a) begin
      mismatched++;
      $display("FAIL %s seg/an got=%h/%h exp=%h/%h", name, seg, an, s, a);
    end
  endtask

  task automatic lit_fd(input string name, input int at, input logic f);
    wait_n(at);
    compared++;
    if (frame_done !== f) begin
      mismatched++;
      $display("FAIL %s frame_done got=%b exp=%b", name, frame_done, f);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    lit("reset_dark", 0, 7'h7F, 4'hF);
    rst = 1'b0;
    lit("zero_d0", 1, 7'h40, 4'hE);
    lit("zero_d1", 5, 7'h40, 4'hD);
    lit("zero_d2", 9, 7'h40, 4'hB);
    lit("zero_d3", 13, 7'h40, 4'h7);
    lit_fd("fd_low", 15, 1'b0);
    lit_fd("fd_pulse", 16, 1'b1);

    wait_n(20);
    BCD_3 = 4'd0; BCD_2 = 4'd7; BCD_1 = 4'd7; BCD_0 = 4'd7;
    blank_lz = 1'b1;
    lit("777_d0", 33, 7'h78, 4'hE);
    lit("777_d1", 37, 7'h78, 4'hD);
    lit("777_d2", 41, 7'h78, 4'hB);
    lit("777_d3_blank", 45, 7'h7F, 4'hF);
    wait_n(50);
    blank_lz = 1'b0;
    lit("0777_d3", 61, 7'h40, 4'h7);
    lit("0777_d0", 65, 7'h78, 4'hE);

    wait_n(70);  // middle of the digit-1 slot
    BCD_0 = 4'd3;
    lit("hold_old_d0", 77, 7'h40, 4'h7);
    lit("new_d0", 81, 7'h30, 4'hE);

    wait_n(85);
    BCD_3 = 4'd12; BCD_2 = 4'd0; BCD_1 = 4'd0; BCD_0 = 4'd5;
    blank_lz = 1'b1;
    lit("inv_d0", 97, 7'h12, 4'hE);
    lit("inv_d1", 101, 7'h40, 4'hD);
    lit("inv_d2", 105, 7'h40, 4'hB);
    lit("inv_d3", 109, 7'h3F, 4'h7);

    wait_n(122);  // digit 2 lit
    rst = 1'b1;
    @(negedge clk);
    lit("midreset_dark", 0, 7'h7F, 4'hF);
    rst = 1'b0;
    lit("after_rst_d0", 1, 7'h40, 4'hE);
    lit("after_rst_d3", 13, 7'h7F, 4'hF);
    lit("after_rst_frame", 17, 7'h12, 4'hE);

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        logic [3:0] v;
        v = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0: BCD_0 = v;
          1: BCD_1 = v;
          2: BCD_2 = v;
          default: BCD_3 = v;
        endcase
      end
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_sevenseg_scan.md
Name: bcd_sevenseg_scan

Overview:
- Downstream consumer of the binary-to-BCD converter. Takes its four BCD digit outputs and drives a 4-digit, common-anode, multiplexed 7-segment display.
- Scans one digit at a time at a programmable refresh rate.
- Samples the BCD inputs into a shadow register once per full scan frame, so a value change never shows half-updated on the display.
- Provides optional leading-zero blanking and a dash glyph for invalid (>9) digits.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit; legal range >= 2.
- CNT_W, $clog2(REFRESH_DIV), width of the refresh divider counter; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- BCD_0  input  4  units digit from the converter.
- BCD_1  input  4  tens digit.
- BCD_2  input  4  hundreds digit.
- BCD_3  input  4  thousands digit.
- blank_lz  input  1  1 = blank leading zeros; sampled every cycle.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit anodes, active-low; an[i] lights digit i.
- frame_done  output  1  one-cycle pulse at the start of each new frame.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst; it is sampled only on rising clk edges.
- Reset values: div_cnt=0, idx=0, shadow digits S0..S3=0, seg=7'h7F, an=4'hF, frame_done=0.
- Divider:
  - If div_cnt==REFRESH_DIV-1: div_cnt<=0 and idx<=idx+1 (2-bit, wraps 3->0).
  - Otherwise div_cnt<=div_cnt+1.
- Shadow load: on the edge where div_cnt==REFRESH_DIV-1 and idx==3, S0..S3 <= BCD_0..BCD_3. This is the only edge on which inputs are captured.
- frame_done: registered; high exactly one cycle, after the same edge that wraps idx 3->0.
- Outputs: seg and an are registered from the current idx and S0..S3, giving 1 cycle of latency.
  - Each digit is shown for exactly REFRESH_DIV consecutive cycles.
  - Exactly one anode is low unless that digit is blanked.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Any value 10..15 = 3F (dash, segment g only).
- Leading-zero blanking, only when blank_lz=1:
  - Digit 3 blanked if S3==0.
  - Digit 2 blanked if S3==0 and S2==0.
  - Digit 1 blanked if S3, S2 and S1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg=7F and an=F.
  - An invalid digit (>9) counts as nonzero and stops blanking of the digits below it.
- First frame after reset displays the reset shadow (value 0). New inputs first appear in frame 2.
- Input changes mid-frame are ignored until the frame boundary. Simultaneous input change and shadow-load edge: the value present at that edge is captured.
- rst asserted mid-frame: all state returns to reset values on that edge. Outputs go dark (an=F, seg=7F) the cycle after. Scanning restarts at digit 0.
- No combinational path from any input to any output.

Test Plan:
- Reset, REFRESH_DIV=4, blank_lz=0, BCD=0/0/0/0 -> first cycle after rst release: an=F, seg=7F. Then an=E,D,B,7, each held 4 cycles, seg=40 throughout. frame_done pulses every 16 cycles.
- Digits 3..0 = 0,7,7,7 (value 777) applied in frame 1, blank_lz=1 -> from frame 2: digit 0/1/2 show seg=78 with an=E/D/B. During the digit-3 slot, an=F and seg=7F.
- Same input with blank_lz=0 -> digit 3 shows seg=40 with an=7. Digits 0..2 show seg=78 (display reads 0777).
- Change BCD_0 from 7 to 3 midway through the digit-1 slot -> the current frame still shows 7 on digit 0. After the next frame_done, digit 0 shows seg=30.
- BCD_3=12, BCD_2=0, BCD_1=0, BCD_0=5, blank_lz=1 -> digit 3 shows 3F, digits 2 and 1 show 40 (not blanked), digit 0 shows 12.
- Assert rst for 1 cycle while digit 2 is lit -> next cycle an=F and seg=7F. Scanning resumes at digit 0 with an=E. The shadow reads 0 until the next frame boundary.
